// File: rtl/receipt_totalizer.sv
// Receipt totalizer: accumulates calculator line results into a saturating subtotal and
// presents a discounted receipt on checkout, held until the consumer accepts it.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_OPEN    | accepting lines; checkout closes the receipt
//   ST_SETTLE  | one cycle: apply discount, latch receipt outputs
//   ST_PRESENT | receipt_valid high, outputs held until receipt_ready
module receipt_totalizer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_valid,
   input  logic [15:0] line_total_in_cents,
   input  logic        line_err,
   output logic        line_ready,
   input  logic        checkout,
   output logic        receipt_valid,
   input  logic        receipt_ready,
   output logic [19:0] receipt_total_in_cents,
   output logic [7:0]  receipt_lines,
   output logic [7:0]  receipt_errs,
   output logic        receipt_sat
);

   typedef enum logic [1:0] {
      ST_OPEN    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   localparam logic [19:0] SUB_MAX     = 20'hFFFFF;
   localparam logic [19:0] DISC_THRESH = 20'd10000;
   localparam logic [19:0] DISC_AMT    = 20'd500;
   localparam logic [7:0]  CNT_MAX     = 8'hFF;

   state_t      state_q, state_d;
   logic [19:0] subtotal_q, subtotal_d;
   logic [7:0]  lines_q, lines_d;
   logic [7:0]  errs_q, errs_d;
   logic        sat_q, sat_d;
   logic [19:0] rtotal_q, rtotal_d;
   logic [7:0]  rlines_q, rlines_d;
   logic [7:0]  rerrs_q, rerrs_d;
   logic        rsat_q, rsat_d;

   logic [20:0] sum;

   assign sum = {1'b0, subtotal_q} + {5'd0, line_total_in_cents};

   always_comb begin
      state_d    = state_q;
      subtotal_d = subtotal_q;
      lines_d    = lines_q;
      errs_d     = errs_q;
      sat_d      = sat_q;
      rtotal_d   = rtotal_q;
      rlines_d   = rlines_q;
      rerrs_d    = rerrs_q;
      rsat_d     = rsat_q;

      case (state_q)
         ST_OPEN: begin
            if (line_valid) begin
               if (line_err) begin
                  // unknown-item lines only bump the error count; their amount is not added
                  if (errs_q != CNT_MAX) errs_d = errs_q + 8'd1;
               end else begin
                  if (sum[20]) begin
                     subtotal_d = SUB_MAX;
                     sat_d      = 1'b1;
                  end else begin
                     subtotal_d = sum[19:0];
                  end
                  if (lines_q != CNT_MAX) lines_d = lines_q + 8'd1;
               end
            end
            if (checkout) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            rtotal_d = (subtotal_q >= DISC_THRESH) ? (subtotal_q - DISC_AMT) : subtotal_q;
            rlines_d = lines_q;
            rerrs_d  = errs_q;
            rsat_d   = sat_q;
            state_d  = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (receipt_ready) begin
               state_d    = ST_OPEN;
               subtotal_d = 20'd0;
               lines_d    = 8'd0;
               errs_d     = 8'd0;
               sat_d      = 1'b0;
            end
         end
         default: state_d = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_OPEN;
         subtotal_q <= 20'd0;
         lines_q    <= 8'd0;
         errs_q     <= 8'd0;
         sat_q      <= 1'b0;
         rtotal_q   <= 20'd0;
         rlines_q   <= 8'd0;
         rerrs_q    <= 8'd0;
         rsat_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         subtotal_q <= subtotal_d;
         lines_q    <= lines_d;
         errs_q     <= errs_d;
         sat_q      <= sat_d;
         rtotal_q   <= rtotal_d;
         rlines_q   <= rlines_d;
         rerrs_q    <= rerrs_d;
         rsat_q     <= rsat_d;
      end
   end

   assign line_ready             = (state_q == ST_OPEN);
   assign receipt_valid          = (state_q == ST_PRESENT);
   assign receipt_total_in_cents = rtotal_q;
   assign receipt_lines          = rlines_q;
   assign receipt_errs           = rerrs_q;
   assign receipt_sat            = rsat_q;

endmodule
